lcd_pixel_writer: RTL

- Sits between the PPU pixel pipeline and the ram_lcd framebuffer write port (port A, clk_4mhz domain).
- Accepts a ready/valid stream of 2-bit colour indices and maps each one through the BGP-style palette.
- Buffers pixels in a small FIFO and writes them in raster order to framebuffer address 160*y+x.
- Reports line and frame completion to the PPU and the video-timing logic.

---
 rtl/lcd_pixel_writer.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/lcd_pixel_writer.sv
// rtl/lcd_pixel_writer.sv - palette-mapping pixel FIFO and raster writer for the ram_lcd framebuffer
//
// Takes 2-bit colour indices from the PPU pixel pipeline on a ready/valid
// handshake. Each index is mapped through the palette register when it is
// accepted, and the resulting shade is queued in a small FIFO. Shades are
// drained in raster order to framebuffer port A at address LCD_W*y + x.
//
// Ports:
//   clk_4mhz        PPU / framebuffer clock
//   rst             synchronous, active-high reset
//   frame_start_in  single-cycle pulse that starts, or restarts, a frame
//   pix_valid_in    a colour index is present on pix_in
//   pix_in          colour index 0..3
//   pix_ready_out   a pixel is accepted this cycle
//   palette_in      palette register; the shade for index i is palette_in[2i+1:2i]
//   hold_in         stalls framebuffer writes while the FIFO keeps filling
//   lcd_addr        framebuffer write address (registered)
//   lcd_data        shade written (registered)
//   lcd_write       write strobe (registered)
//   x_out, y_out    column and line of the next write
//   line_done       one-cycle pulse that accompanies the write of column LCD_W-1
//   frame_done      one-cycle pulse one cycle after the last write of the frame
//   drop_err        sticky flag: a pixel was offered outside RUN
//   state_out       FSM state (IDLE=0, RUN=1, DONE=2), for debug

module lcd_pixel_writer #(
    parameter int LCD_W      = 160,
    parameter int LCD_H      = 144,
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = 15
) (
    input  logic              clk_4mhz,
    input  logic              rst,
    input  logic              frame_start_in,
    input  logic              pix_valid_in,
    input  logic [1:0]        pix_in,
    output logic              pix_ready_out,
    input  logic [7:0]        palette_in,
    input  logic              hold_in,
    output logic [ADDR_W-1:0] lcd_addr,
    output logic [1:0]        lcd_data,
    output logic              lcd_write,
    output logic [7:0]        x_out,
    output logic [7:0]        y_out,
    output logic              line_done,
    output logic              frame_done,
    output logic              drop_err,
    output logic [1:0]        state_out
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
    localparam logic [7:0]        X_LAST   = 8'(LCD_W - 1);
    localparam logic [7:0]        Y_LAST   = 8'(LCD_H - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_BACK = ADDR_W'(LCD_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [1:0]          fifo_q [FIFO_DEPTH];
    logic [1:0]          fifo_d [FIFO_DEPTH];
    logic [7:0]          x_q, x_d;
    logic [7:0]          y_q, y_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   lcd_addr_q, lcd_addr_d;
    logic [1:0]          lcd_data_q, lcd_data_d;
    logic                lcd_write_q, lcd_write_d;
    logic                line_done_q, line_done_d;
    logic                frame_done_q, frame_done_d;
    logic                drop_err_q, drop_err_d;

    logic                ready;
    logic                push;
    logic                pop;
    logic [1:0]          shade_in;

    // Palette lookup at accept time; queued shades are immune to later
    // palette writes.
    always_comb begin
        shade_in = 2'd0;
        case (pix_in)
            2'd0: shade_in = palette_in[1:0];
            2'd1: shade_in = palette_in[3:2];
            2'd2: shade_in = palette_in[5:4];
            2'd3: shade_in = palette_in[7:6];
            default: shade_in = 2'd0;
        endcase
    end

    // Ready looks only at the registered count, so a full FIFO refuses a
    // pixel even in a cycle that also pops.
    assign ready = (state_q == ST_RUN) && (cnt_q < CNT_FULL);
    assign push  = pix_valid_in && ready && !frame_start_in;
    assign pop   = (state_q == ST_RUN) && (cnt_q != '0) && !hold_in && !frame_start_in;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        fifo_d       = fifo_q;
        x_d          = x_q;
        y_d          = y_q;
        addr_d       = addr_q;
        lcd_addr_d   = lcd_addr_q;
        lcd_data_d   = lcd_data_q;
        lcd_write_d  = 1'b0;
        line_done_d  = 1'b0;
        frame_done_d = 1'b0;
        drop_err_d   = drop_err_q;

        if (push) begin
            fifo_d[wr_ptr_q] = shade_in;
            wr_ptr_d         = wr_ptr_q + PTR_ONE;
        end

        if (pop) begin
            lcd_write_d = 1'b1;
            lcd_addr_d  = addr_q;
            lcd_data_d  = fifo_q[rd_ptr_q];
            rd_ptr_d    = rd_ptr_q + PTR_ONE;
            if (x_q == X_LAST) begin
                x_d         = 8'd0;
                line_done_d = 1'b1;
                if (y_q == Y_LAST) begin
                    // Final pixel: y stays on the last line, x wraps, and
                    // the address is rewound to the start of that line so
                    // it still equals LCD_W*y + x.
                    addr_d  = addr_q - ADDR_BACK;
                    state_d = ST_DONE;
                end else begin
                    y_d    = y_q + 8'd1;
                    addr_d = addr_q + ADDR_ONE;
                end
            end else begin
                x_d    = x_q + 8'd1;
                addr_d = addr_q + ADDR_ONE;
            end
        end

        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase

        case (state_q)
            ST_DONE: begin
                frame_done_d = 1'b1;
                state_d      = ST_IDLE;
            end
            default: ;
        endcase

        if (pix_valid_in && (state_q != ST_RUN)) begin
            drop_err_d = 1'b1;
        end

        // A frame start from any state begins a fresh frame. From RUN or
        // DONE this is an abort: queued pixels are discarded and the
        // pending frame_done is suppressed.
        if (frame_start_in) begin
            state_d      = ST_RUN;
            cnt_d        = '0;
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            x_d          = 8'd0;
            y_d          = 8'd0;
            addr_d       = '0;
            frame_done_d = 1'b0;
        end
    end

    always_ff @(posedge clk_4mhz) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            x_q          <= 8'd0;
            y_q          <= 8'd0;
            addr_q       <= '0;
            lcd_addr_q   <= '0;
            lcd_data_q   <= 2'd0;
            lcd_write_q  <= 1'b0;
            line_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
            drop_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            x_q          <= x_d;
            y_q          <= y_d;
            addr_q       <= addr_d;
            lcd_addr_q   <= lcd_addr_d;
            lcd_data_q   <= lcd_data_d;
            lcd_write_q  <= lcd_write_d;
            line_done_q  <= line_done_d;
            frame_done_q <= frame_done_d;
            drop_err_q   <= drop_err_d;
        end
    end

    // FIFO storage carries no reset; the count and pointers define which
    // entries are valid.
    always_ff @(posedge clk_4mhz) begin
        fifo_q <= fifo_d;
    end

    assign pix_ready_out = ready;
    assign lcd_addr      = lcd_addr_q;
    assign lcd_data      = lcd_data_q;
    assign lcd_write     = lcd_write_q;
    assign x_out         = x_q;
    assign y_out         = y_q;
    assign line_done     = line_done_q;
    assign frame_done    = frame_done_q;
    assign drop_err      = drop_err_q;
    assign state_out     = state_q;

endmodule
